load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 Parameter DMEM_BYTES, default 1024, SHALL give the data memory size in bytes.
REQ-003 reqValid  in  1  pipeline presents an access.
REQ-004 reqReady  out  1  block can accept an access.
REQ-005 reqWrite  in  1  1 = store, 0 = load.
REQ-006 reqSize  in  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-007 reqUnsigned  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
REQ-008 reqAddr  in  32  byte address; reqWdata  in  32  store data, right-justified.
REQ-009 respValid  out  1  one-cycle completion pulse; respErr  out  1  fault flag, valid with respValid.
REQ-010 respRdata  out  32  extended load data, valid with respValid; 0 for stores and faults.
REQ-011 memRead  out  1; memWrite  out  1; memAddress  out  32; memWriteData  out  32  (to data memory).
REQ-012 memReadData  in  32  data memory output, registered by memory on the clk edge where memRead=1.

Function
REQ-013 Memory byte order SHALL be big-endian: byte offset k maps to word bits [31-8k : 24-8k]; halfword offset 0 -> [31:16], offset 2 -> [15:0].
REQ-014 memAddress SHALL always be word-aligned ({addr[31:2],2'b00}); memRead and memWrite SHALL never both be 1.
REQ-015 FSM states SHALL be IDLE, LD_REQ, LD_CAP, ST_RD, ST_MERGE, ST_WR, RESP; all memory outputs and response outputs SHALL be registered (Moore).
REQ-016 reqReady SHALL be 1 only in IDLE; an access is accepted on a clk edge with reqValid=1 and reqReady=1, and all request fields are latched then.
REQ-017 Fault: misaligned halfword (addr[0]=1), misaligned word (addr[1:0]!=0), reqSize=11, or addr > DMEM_BYTES-4 for the aligned word SHALL go IDLE->RESP with respErr=1 and no memory access.
REQ-018 Load: IDLE->LD_REQ (memRead=1) ->LD_CAP (sample memReadData, extract, extend) ->RESP; respValid 3 cycles after accept.
REQ-019 Word store: IDLE->ST_WR (memWrite=1, memWriteData=reqWdata) ->RESP; respValid 2 cycles after accept.
REQ-020 Byte/halfword store SHALL be read-modify-write: ST_RD (memRead=1) ->ST_MERGE (replace addressed lane with reqWdata[7:0] or [15:0], keep other bytes) ->ST_WR ->RESP; respValid 4 cycles after accept.
REQ-021 RESP SHALL last exactly one cycle then return to IDLE; responses have no backpressure.
REQ-022 reqValid while not in IDLE SHALL be ignored (not queued); a request accepted in IDLE following RESP is legal back-to-back.

Reset
REQ-023 On rst_n=0 (any state, asynchronously): state IDLE, reqReady=0 until the first edge after release then 1, memRead=0, memWrite=0, memAddress=0, memWriteData=0, respValid=0, respErr=0, respRdata=0.
REQ-024 Reset mid-access SHALL abandon the access with no response; a partially completed RMW SHALL NOT issue its write.

Structure
REQ-025 Package lsu_pkg SHALL hold the state enum, reqSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and DMEM_BYTES default.
REQ-026 One combinational sub-module lsu_align SHALL perform load lane extraction/extension and store lane merge; the FSM stays in load_store_unit.

Verification
REQ-027 Memory word 0x40 = 0x8899AABB; lb addr 0x41 -> respRdata 0xFFFFFF99, respErr=0, respValid 3 cycles after accept.
REQ-028 Same word; lhu addr 0x42 -> 0x0000AABB; lh addr 0x40 -> 0xFFFF8899.
REQ-029 sb addr 0x43, reqWdata 0x12345677 -> memory word 0x40 becomes 0x8899AA77; respValid 4 cycles after accept; exactly one memRead then one memWrite seen.
REQ-030 sw addr 0x3FC data 0xDEADBEEF -> word written, respValid 2 cycles after accept; sw addr 0x400 and lh addr 0x41 -> respErr=1 after 1 cycle, memRead/memWrite stay 0.
REQ-031 Assert rst_n=0 during ST_MERGE of an sh -> memWrite never pulses, respValid stays 0, memory word unchanged, reqReady=1 after release.
REQ-032 Random back-to-back loads/stores against a reference memory model -> all respRdata match, memRead&memWrite never both high, memAddress[1:0] always 00.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access-size
// encodings and the default data-memory size.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_CAP,
    ST_RD,
    ST_MERGE,
    ST_WR,
    RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DMEM_BYTES_DEFAULT = 1024;

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane handling: extracts and extends load data, and merges a
// byte/halfword store into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  // Byte k lives at bits [31-8k -: 8], so its right-shift is 8*(3-k).
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;

  assign byte_sh   = {~offset_i, 3'b000};
  assign half_sh   = {~offset_i[1], 4'b0000};
  assign byte_word = rdata_i >> byte_sh;
  assign half_word = rdata_i >> half_sh;

  always_comb begin
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{~unsigned_i & byte_word[7]}}, byte_word[7:0]};
        merge_o = (rdata_i & ~(32'h0000_00ff << byte_sh)) | ({24'h0, wdata_i[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_o  = {{16{~unsigned_i & half_word[15]}}, half_word[15:0]};
        merge_o = (rdata_i & ~(32'h0000_ffff << half_sh)) | ({16'h0, wdata_i[15:0]} << half_sh);
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time against a registered-read data memory,
// with read-modify-write for sub-word stores and Moore-registered outputs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        respValid,
  output logic        respErr,
  output logic [31:0] respRdata,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  localparam logic [31:0] LastWord = 32'(DMEM_BYTES - 4);

  lsu_state_e  state_q, state_d;
  logic [1:0]  size_q, off_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        ready_q, ready_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        fault;
  logic [31:0] word_addr;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign accept    = reqValid & ready_q;
  assign word_addr = {reqAddr[31:2], 2'b00};
  assign fault     = (reqSize == 2'b11) ||
                     ((reqSize == SZ_HALF) && reqAddr[0]) ||
                     ((reqSize == SZ_WORD) && (reqAddr[1:0] != 2'b00)) ||
                     (word_addr > LastWord);

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .offset_i   (off_q),
    .rdata_i    (memReadData),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault)                   state_d = RESP;
          else if (!reqWrite)          state_d = LD_REQ;
          else if (reqSize == SZ_WORD) state_d = ST_WR;
          else                         state_d = ST_RD;
        end
      end
      LD_REQ:   state_d = LD_CAP;
      LD_CAP:   state_d = RESP;
      ST_RD:    state_d = ST_MERGE;
      ST_MERGE: state_d = ST_WR;
      ST_WR:    state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with it (Moore).
  always_comb begin
    ready_d      = (state_d == IDLE);
    mem_rd_d     = (state_d == LD_REQ) || (state_d == ST_RD);
    mem_wr_d     = (state_d == ST_WR);
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = (state_d == RESP);
    resp_err_d   = (state_q == IDLE) && accept && fault;
    resp_rdata_d = (state_q == LD_CAP) ? load_data : 32'h0;
    if ((state_q == IDLE) && accept) begin
      mem_addr_d  = word_addr;
      mem_wdata_d = reqWdata;
    end
    if (state_q == ST_MERGE) begin
      mem_wdata_d = merge_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
      ready_q      <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      if ((state_q == IDLE) && accept) begin
        size_q  <= reqSize;
        off_q   <= reqAddr[1:0];
        uns_q   <= reqUnsigned;
        wdata_q <= reqWdata;
      end
    end
  end

  assign reqReady     = ready_q;
  assign memRead      = mem_rd_q;
  assign memWrite     = mem_wr_q;
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign respValid    = resp_valid_q;
  assign respErr      = resp_err_q;
  assign respRdata    = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random back-to-back accesses
// compared against a byte-array reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        respValid, respErr;
  logic [31:0] respRdata;
  logic        memRead, memWrite;
  logic [31:0] memAddress, memWriteData, memReadData;

  always #5 clk = ~clk;

  load_store_unit #(.DMEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqSize      (reqSize),
    .reqUnsigned  (reqUnsigned),
    .reqAddr      (reqAddr),
    .reqWdata     (reqWdata),
    .respValid    (respValid),
    .respErr      (respErr),
    .respRdata    (respRdata),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  // Data memory with a backdoor write port for initialisation.
  logic [31:0] dmem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) dmem[bd_addr] <= bd_data;
    else if (memWrite) dmem[memAddress[9:2]] <= memWriteData;
    if (memRead) memReadData <= dmem[memAddress[9:2]];
  end

  int unsigned rd_total = 0, wr_total = 0, resp_total = 0;
  logic        both_seen = 1'b0, misalign_seen = 1'b0;

  always @(posedge clk) begin
    if (memRead) rd_total <= rd_total + 1;
    if (memWrite) wr_total <= wr_total + 1;
    if (respValid) resp_total <= resp_total + 1;
    if (memRead && memWrite) both_seen <= 1'b1;
    if (memAddress[1:0] != 2'b00) misalign_seen <= 1'b1;
  end

  // Reference model: plain byte array, big-endian.
  logic [7:0] ref_mem [1024];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] base;
    base = (a / 4) * 4;
    if (sz == 2'b11) return 1'b1;
    if (sz == SZ_HALF && (a % 2) != 0) return 1'b1;
    if (sz == SZ_WORD && (a % 4) != 0) return 1'b1;
    return (base > 32'd1020);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    v  = 32'h0;
    for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hffff_ffff << (8 * nb));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * (nb - 1 - i)));
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
  endfunction

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input bit noise,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int nrd, output int nwr);
    int n;
    int unsigned rd0, wr0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = uns;
    reqAddr  = a;    reqWdata = wd;
    n = 0;
    while (!reqReady && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("ready", {31'b0, reqReady}, 32'd1);
    rd0 = rd_total;
    wr0 = wr_total;
    @(posedge clk);
    #1;
    // Junk request while busy must be ignored and must not disturb latched fields.
    if (noise) begin
      reqWrite = 1'($urandom); reqSize = 2'($urandom); reqUnsigned = 1'($urandom);
      reqAddr  = $urandom;     reqWdata = $urandom;
    end else begin
      reqValid = 1'b0;
    end
    lat = 1;
    while (!respValid && lat < 8) begin
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      lat++;
    end
    reqValid = 1'b0;
    rdata = respRdata;
    err   = respErr;
    nrd   = int'(rd_total - rd0);
    nwr   = int'(wr_total - wr0);
  endtask

  task automatic run_check(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input bit noise, output logic [31:0] got);
    logic        e_err, g_err;
    logic [31:0] e_rdata;
    int          e_lat, e_rd, e_wr, g_lat, g_rd, g_wr;
    e_err   = ref_fault(sz, a);
    e_rdata = (!wr && !e_err) ? ref_load(sz, uns, a) : 32'h0;
    e_lat   = e_err ? 1 : (!wr ? 3 : (sz == SZ_WORD ? 2 : 4));
    e_rd    = e_err ? 0 : ((!wr || sz != SZ_WORD) ? 1 : 0);
    e_wr    = (e_err || !wr) ? 0 : 1;
    do_access(wr, sz, uns, a, wd, noise, got, g_err, g_lat, g_rd, g_wr);
    if (wr && !e_err) ref_store(sz, a, wd);
    check({tag, "_rdata"}, got, e_rdata);
    check({tag, "_err"}, {31'b0, g_err}, {31'b0, e_err});
    check({tag, "_lat"}, 32'(g_lat), 32'(e_lat));
    check({tag, "_nrd"}, 32'(g_rd), 32'(e_rd));
    check({tag, "_nwr"}, 32'(g_wr), 32'(e_wr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got, v, old;
    logic        wr, uns, noise;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r, mism;
    int unsigned wr0, resp0;

    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 32'h0; reqWdata = 32'h0; bd_we = 1'b1; bd_addr = 8'h0; bd_data = 32'h0;

    for (int w = 0; w < 256; w++) begin
      @(negedge clk);
      v = (w == 16) ? 32'h8899_aabb : $urandom;
      bd_addr = 8'(w);
      bd_data = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = 8'(v >> (8 * (3 - b)));
    end
    @(negedge clk);
    bd_we = 1'b0;

    check("rst_ready", {31'b0, reqReady}, 32'd0);
    check("rst_memrd", {31'b0, memRead}, 32'd0);
    check("rst_memwr", {31'b0, memWrite}, 32'd0);
    check("rst_addr", memAddress, 32'h0);
    check("rst_wdata", memWriteData, 32'h0);
    check("rst_resp", {30'b0, respValid, respErr}, 32'd0);
    check("rst_rdata", respRdata, 32'h0);

    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'b0, reqReady}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", {31'b0, reqReady}, 32'd1);

    // Directed cases on word 0x40 = 0x8899AABB.
    run_check("lb41", 1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, 1'b0, got);
    check("lb41_val", got, 32'hffff_ff99);
    run_check("lhu42", 1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 1'b0, got);
    check("lhu42_val", got, 32'h0000_aabb);
    run_check("lh40", 1'b0, SZ_HALF, 1'b0, 32'h40, 32'h0, 1'b0, got);
    check("lh40_val", got, 32'hffff_8899);
    run_check("sb43", 1'b1, SZ_BYTE, 1'b0, 32'h43, 32'h1234_5677, 1'b0, got);
    check("sb43_mem", dmem[16], 32'h8899_aa77);
    run_check("sw3fc", 1'b1, SZ_WORD, 1'b0, 32'h3fc, 32'hdead_beef, 1'b0, got);
    check("sw3fc_mem", dmem[255], 32'hdead_beef);
    run_check("sw400", 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h1111_1111, 1'b0, got);
    run_check("lh41", 1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, 1'b0, got);
    run_check("sz11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, got);
    run_check("lbu3ff", 1'b0, SZ_BYTE, 1'b1, 32'h3ff, 32'h0, 1'b0, got);
    check("lbu3ff_val", got, 32'h0000_00ef);

    // Reset during ST_MERGE of a halfword store: the write must never happen.
    old = dmem[20];
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = SZ_HALF; reqAddr = 32'h52; reqWdata = 32'hcafe;
    r = 0;
    while (!reqReady && r < 16) begin
      @(negedge clk);
      r++;
    end
    wr0 = wr_total;
    resp0 = resp_total;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_memwr", {31'b0, memWrite}, 32'd0);
    check("midrst_ready", {31'b0, reqReady}, 32'd0);
    check("midrst_addr", memAddress, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_rel", {31'b0, reqReady}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_nwr", wr_total - wr0, 32'd0);
    check("midrst_nresp", resp_total - resp0, 32'd0);
    check("midrst_mem", dmem[20], old);

    // Random back-to-back accesses.
    for (int i = 0; i < 200; i++) begin
      wr    = 1'($urandom);
      uns   = 1'($urandom);
      noise = 1'($urandom);
      r     = int'($urandom_range(0, 15));
      sz    = (r == 0) ? 2'b11 : 2'(r % 3);
      r     = int'($urandom_range(0, 19));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h3fc + 32'($urandom_range(0, 19));
      else             a = 32'($urandom_range(0, 1023));
      if (sz != 2'b11 && $urandom_range(0, 7) != 0) a = (a >> sz) << sz;
      run_check("rnd", wr, sz, uns, a, $urandom, noise, got);
    end

    repeat (2) @(posedge clk);
    #1;
    check("never_both", {31'b0, both_seen}, 32'd0);
    check("addr_aligned", {31'b0, misalign_seen}, 32'd0);
    mism = 0;
    for (int w = 0; w < 256; w++) if (dmem[w] !== ref_word(w)) mism++;
    check("mem_final", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
